// File: rtl/acondicionador_botones_pkg.sv
// Shared constants for the push-button conditioner: edge modes, the repeat-FSM
// state encoding and a width helper.
package acondicionador_pkg;

    localparam int MODO_SUBIDA = 0;
    localparam int MODO_BAJADA = 1;
    localparam int MODO_AMBOS  = 2;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        ESPERA     = 2'd1,
        REPITIENDO = 2'd2
    } estado_rep_t;

    function automatic int clog2(input int valor);
        int resultado;
        int resto;
        resultado = 0;
        resto = valor - 1;
        for (int i = 0; i < 32; i++) begin
            if (resto > 0) begin
                resultado = resultado + 1;
                resto = resto >> 1;
            end
        end
        return resultado;
    endfunction

endpackage

// File: rtl/acondicionador_botones_if.sv
// Button bus between the raw board inputs and the conditioner outputs.
interface acondicionador_botones_if #(
    parameter int N_CANALES = 4
);
    logic [N_CANALES-1:0] botones;
    logic [N_CANALES-1:0] presionado;
    logic [N_CANALES-1:0] impulsos;

    modport master (output botones, input presionado, input impulsos);
    modport slave  (input botones, output presionado, output impulsos);
endinterface

// File: rtl/acondicionador_botones_canal.sv
// One button channel: two-flop synchroniser, debounce, edge impulse and
// typematic repeat.
//
// state      | meaning
// REPOSO     | idle, waiting for a debounced press
// ESPERA     | held, counting the initial repeat delay
// REPITIENDO | held, emitting a repeat impulse every period
module canal_boton
    import acondicionador_pkg::*;
#(
    parameter int MODO              = MODO_SUBIDA,
    parameter int CICLOS_ESTABLE    = 16,
    parameter int HABILITAR_REPETIR = 1,
    parameter int RETARDO_REPETIR   = 500,
    parameter int PERIODO_REPETIR   = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic boton,
    output logic presionado,
    output logic impulso
);

    localparam int W_REB   = clog2(CICLOS_ESTABLE) + 1;
    localparam int REP_MAX = (RETARDO_REPETIR > PERIODO_REPETIR) ? RETARDO_REPETIR : PERIODO_REPETIR;
    localparam int W_REP   = clog2(REP_MAX) + 1;

    localparam logic [W_REB-1:0] REB_TC = W_REB'(CICLOS_ESTABLE - 1);
    localparam logic [W_REP-1:0] RET_TC = W_REP'(RETARDO_REPETIR - 1);
    localparam logic [W_REP-1:0] PER_TC = W_REP'(PERIODO_REPETIR - 1);

    localparam bit EMITE_SUBIDA   = (MODO == MODO_SUBIDA) || (MODO == MODO_AMBOS);
    localparam bit EMITE_BAJADA   = (MODO == MODO_BAJADA) || (MODO == MODO_AMBOS);
    localparam bit REPETIR_ACTIVO = (HABILITAR_REPETIR == 1) && EMITE_SUBIDA;

    logic             sinc1, sinc2, estable;
    logic [W_REB-1:0] contador_rebote;
    logic             imp_borde;

    estado_rep_t      estado, estado_sig;
    logic [W_REP-1:0] contador_rep, contador_rep_sig;
    logic             imp_rep, imp_rep_sig;

    logic flanco_listo, subida, bajada;

    // The debounced level flips on this edge; shared by the edge logic and the FSM.
    assign flanco_listo = (sinc2 != estable) && (contador_rebote == REB_TC);
    assign subida       = flanco_listo && sinc2;
    assign bajada       = flanco_listo && !sinc2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc1           <= 1'b0;
            sinc2           <= 1'b0;
            estable         <= 1'b0;
            contador_rebote <= '0;
            imp_borde       <= 1'b0;
        end else begin
            sinc1     <= boton;
            sinc2     <= sinc1;
            imp_borde <= (subida && EMITE_SUBIDA) || (bajada && EMITE_BAJADA);
            if (sinc2 == estable) begin
                contador_rebote <= '0;
            end else if (flanco_listo) begin
                estable         <= sinc2;
                contador_rebote <= '0;
            end else begin
                contador_rebote <= contador_rebote + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= REPOSO;
            contador_rep <= '0;
            imp_rep      <= 1'b0;
        end else begin
            estado       <= estado_sig;
            contador_rep <= contador_rep_sig;
            imp_rep      <= imp_rep_sig;
        end
    end

    // A release always beats a terminal count in the same cycle.
    always_comb begin
        estado_sig       = estado;
        contador_rep_sig = contador_rep;
        imp_rep_sig      = 1'b0;
        if (!REPETIR_ACTIVO) begin
            estado_sig       = REPOSO;
            contador_rep_sig = '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (subida) begin
                        estado_sig       = ESPERA;
                        contador_rep_sig = '0;
                    end
                end
                ESPERA: begin
                    if (bajada) begin
                        estado_sig       = REPOSO;
                        contador_rep_sig = '0;
                    end else if (contador_rep == RET_TC) begin
                        estado_sig       = REPITIENDO;
                        contador_rep_sig = '0;
                        imp_rep_sig      = 1'b1;
                    end else begin
                        contador_rep_sig = contador_rep + 1'b1;
                    end
                end
                REPITIENDO: begin
                    if (bajada) begin
                        estado_sig       = REPOSO;
                        contador_rep_sig = '0;
                    end else if (contador_rep == PER_TC) begin
                        contador_rep_sig = '0;
                        imp_rep_sig      = 1'b1;
                    end else begin
                        contador_rep_sig = contador_rep + 1'b1;
                    end
                end
                default: begin
                    estado_sig       = REPOSO;
                    contador_rep_sig = '0;
                end
            endcase
        end
    end

    assign presionado = estable;
    assign impulso    = imp_borde | imp_rep;

endmodule

// File: rtl/acondicionador_botones.sv
// N independent button channels; the top is only the per-channel replication.
module acondicionador_botones
    import acondicionador_pkg::*;
#(
    parameter int N_CANALES         = 4,
    parameter int MODO              = MODO_SUBIDA,
    parameter int CICLOS_ESTABLE    = 16,
    parameter int HABILITAR_REPETIR = 1,
    parameter int RETARDO_REPETIR   = 500,
    parameter int PERIODO_REPETIR   = 100
) (
    input logic               clock,
    input logic               reset,
    acondicionador_botones_if.slave io
);

    for (genvar i = 0; i < N_CANALES; i++) begin : gen_canal
        canal_boton #(
            .MODO              (MODO),
            .CICLOS_ESTABLE    (CICLOS_ESTABLE),
            .HABILITAR_REPETIR (HABILITAR_REPETIR),
            .RETARDO_REPETIR   (RETARDO_REPETIR),
            .PERIODO_REPETIR   (PERIODO_REPETIR)
        ) u_canal (
            .clock      (clock),
            .reset      (reset),
            .boton      (io.botones[i]),
            .presionado (io.presionado[i]),
            .impulso    (io.impulsos[i])
        );
    end

endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed bench: one rising-edge instance and one both-edges instance, with
// CICLOS_ESTABLE=4, RETARDO_REPETIR=10, PERIODO_REPETIR=3.
module tb_acondicionador_botones;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    acondicionador_botones_if #(.N_CANALES(4)) io0 ();
    acondicionador_botones_if #(.N_CANALES(4)) io2 ();

    acondicionador_botones #(
        .N_CANALES(4), .MODO(0), .CICLOS_ESTABLE(4), .HABILITAR_REPETIR(1),
        .RETARDO_REPETIR(10), .PERIODO_REPETIR(3)
    ) dut0 (
        .clock (clock),
        .reset (reset),
        .io    (io0.slave)
    );

    acondicionador_botones #(
        .N_CANALES(4), .MODO(2), .CICLOS_ESTABLE(4), .HABILITAR_REPETIR(1),
        .RETARDO_REPETIR(10), .PERIODO_REPETIR(3)
    ) dut2 (
        .clock (clock),
        .reset (reset),
        .io    (io2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io0.botones = 4'b0000;
        io2.botones = 4'b0000;
        idle(3);
        n_cmp++;
        if (io0.presionado !== 4'b0000 || io0.impulsos !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_dut0 got pres=%b imp=%b want 0000/0000", io0.presionado, io0.impulsos);
        end
        n_cmp++;
        if (io2.presionado !== 4'b0000 || io2.impulsos !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_dut2 got pres=%b imp=%b want 0000/0000", io2.presionado, io2.impulsos);
        end
        reset = 1'b0;
        idle(5);
    endtask

    // ch0 held for edges 0..7: press impulse at edge 5, repeat cancelled by release at 13.
    task automatic test_clean_press();
        logic exp_imp, exp_pres;
        for (int e = 0; e < 30; e++) begin
            io0.botones[0] = (e < 8);
            step();
            exp_imp  = (e == 5);
            exp_pres = (e >= 5 && e <= 12);
            n_cmp++;
            if (io0.impulsos[0] !== exp_imp || io0.presionado[0] !== exp_pres) begin
                n_err++;
                $display("FAIL clean_press e=%0d got imp=%b pres=%b want imp=%b pres=%b",
                         e, io0.impulsos[0], io0.presionado[0], exp_imp, exp_pres);
            end
        end
    endtask

    // Glitches of 1,2,3 cycles then a 6-cycle press starting at edge 9.
    task automatic test_bounce();
        logic [15:0] patron;
        logic exp_imp, exp_pres;
        patron = 16'b0111_1110_1110_1101;
        for (int e = 0; e < 32; e++) begin
            io0.botones[1] = (e < 16) ? patron[e] : 1'b0;
            step();
            exp_imp  = (e == 14);
            exp_pres = (e >= 14 && e <= 19);
            n_cmp++;
            if (io0.impulsos[1] !== exp_imp || io0.presionado[1] !== exp_pres) begin
                n_err++;
                $display("FAIL bounce e=%0d got imp=%b pres=%b want imp=%b pres=%b",
                         e, io0.impulsos[1], io0.presionado[1], exp_imp, exp_pres);
            end
        end
    endtask

    // ch2 held for 40 edges; the release at edge 45 lands on a repeat terminal count.
    task automatic test_repeat();
        logic exp_imp, exp_pres;
        for (int e = 0; e < 64; e++) begin
            io0.botones[2] = (e < 40);
            step();
            exp_imp  = (e == 5) || (e >= 15 && e <= 42 && ((e - 15) % 3) == 0);
            exp_pres = (e >= 5 && e <= 44);
            n_cmp++;
            if (io0.impulsos[2] !== exp_imp || io0.presionado[2] !== exp_pres) begin
                n_err++;
                $display("FAIL repeat e=%0d got imp=%b pres=%b want imp=%b pres=%b",
                         e, io0.impulsos[2], io0.presionado[2], exp_imp, exp_pres);
            end
        end
        // A fresh press must restart from the initial delay, proving REPOSO was reached.
        for (int e = 0; e < 20; e++) begin
            io0.botones[2] = (e < 12);
            step();
            exp_imp = (e == 5) || (e == 15);
            n_cmp++;
            if (io0.impulsos[2] !== exp_imp) begin
                n_err++;
                $display("FAIL repeat_again e=%0d got imp=%b want imp=%b", e, io0.impulsos[2], exp_imp);
            end
        end
        io0.botones[2] = 1'b0;
        idle(15);
    endtask

    // Both-edges mode: ch0 and ch3 pressed together; release impulse at 45 replaces the repeat.
    task automatic test_both_edges();
        logic exp_imp;
        for (int e = 0; e < 60; e++) begin
            io2.botones[0] = (e < 40);
            io2.botones[3] = (e < 40);
            step();
            exp_imp = (e == 5) || (e >= 15 && e <= 42 && ((e - 15) % 3) == 0) || (e == 45);
            n_cmp++;
            if (io2.impulsos !== {exp_imp, 2'b00, exp_imp}) begin
                n_err++;
                $display("FAIL both_edges e=%0d got imp=%b want imp=%b",
                         e, io2.impulsos, {exp_imp, 2'b00, exp_imp});
            end
        end
    endtask

    // Reset lands while ch0 is repeating (would repeat at edge 21); input stays high.
    task automatic test_reset_mid_repeat();
        logic exp_imp, exp_pres;
        for (int e = 0; e < 21; e++) begin
            io0.botones[0] = 1'b1;
            step();
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if (io0.presionado !== 4'b0000 || io0.impulsos !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid_repeat got pres=%b imp=%b want 0000/0000", io0.presionado, io0.impulsos);
        end
        reset = 1'b0;
        for (int e = 22; e < 40; e++) begin
            step();
            exp_imp  = (e == 27) || (e == 37);
            exp_pres = (e >= 27);
            n_cmp++;
            if (io0.impulsos[0] !== exp_imp || io0.presionado[0] !== exp_pres) begin
                n_err++;
                $display("FAIL after_reset e=%0d got imp=%b pres=%b want imp=%b pres=%b",
                         e, io0.impulsos[0], io0.presionado[0], exp_imp, exp_pres);
            end
        end
        io0.botones[0] = 1'b0;
        idle(15);
        n_cmp++;
        if (io0.presionado !== 4'b0000) begin
            n_err++;
            $display("FAIL settle got pres=%b want 0000", io0.presionado);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_both_edges();
        test_reset_mid_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
